// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Bundle of instruction/data-memory handshakes, decoder-style
//                control outputs and state view of the multicycle controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_if;
    logic [6:0] opcode;
    logic       imem_ready;
    logic       dmem_ready;
    logic       trap_clr;
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       retire;
    logic       trap;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       alusrc;
    logic       reg_write;
    logic       mux_inp;
    logic [1:0] memtoreg;
    logic [2:0] aluop;
    logic [2:0] state;

    // Controller side
    modport master (
        input  opcode, imem_ready, dmem_ready, trap_clr,
        output imem_req, ir_write, pc_write, retire, trap, branch, memread,
               memwrite, alusrc, reg_write, mux_inp, memtoreg, aluop, state
    );

    // Datapath / memory side
    modport slave (
        output opcode, imem_ready, dmem_ready, trap_clr,
        input  imem_req, ir_write, pc_write, retire, trap, branch, memread,
               memwrite, alusrc, reg_write, mux_inp, memtoreg, aluop, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle RV32I
//                style datapath, with memory-wait watchdog and TRAP state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int WAIT_MAX = 15
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    multicycle_control_if.master bus
);

    localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CW-1:0] C_WAIT_MAX = CW'(WAIT_MAX);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILL
    } cls_t;

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0010011: classify = C_I;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BR;
            7'b1101111: classify = C_JAL;
            7'b1100111: classify = C_JALR;
            7'b0110111: classify = C_LUI;
            7'b0010111: classify = C_AUIPC;
            default:    classify = C_ILL;
        endcase
    endfunction

    state_t         state_q, state_d;
    logic [6:0]     op_q;
    logic [CW-1:0]  wcnt_q, wcnt_d;
    cls_t           w_cls;      // class of the latched instruction
    cls_t           w_cls_in;   // class of the opcode presented in DECODE

    assign w_cls    = classify(op_q);
    assign w_cls_in = classify(bus.opcode);

    // Next-state and watchdog counter; a ready seen at WAIT_MAX wins over the trap
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready)          state_d = S_DECODE;
                else if (wcnt_q == C_WAIT_MAX) state_d = S_TRAP;
            end
            S_DECODE: state_d = (w_cls_in == C_ILL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (w_cls)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_BR:            state_d = S_FETCH;
                    C_ILL:           state_d = S_TRAP;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready)            state_d = (w_cls == C_LOAD) ? S_WB : S_FETCH;
                else if (wcnt_q == C_WAIT_MAX) state_d = S_TRAP;
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  if (bus.trap_clr) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase

        if ((state_d != state_q) && (state_d == S_FETCH || state_d == S_MEM)) begin
            wcnt_d = '0;
        end else if (((state_q == S_FETCH) && !bus.imem_ready) ||
                     ((state_q == S_MEM)   && !bus.dmem_ready)) begin
            if (wcnt_q != C_WAIT_MAX) wcnt_d = wcnt_q + CW'(1);
        end
    end

    // State, latched opcode and wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 7'd0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_DECODE) op_q <= bus.opcode;
        end
    end

    // Output decode; forced to reset values while rst_n is low, independent of clk
    always_comb begin
        logic       l_alusrc;
        logic [2:0] l_aluop;
        logic       l_branch;
        logic       l_mux;
        logic [1:0] l_m2r;

        // Per-class ALU controls and write-back source
        l_alusrc = 1'b1; l_aluop = 3'b000; l_branch = 1'b0; l_mux = 1'b0; l_m2r = 2'b11;
        case (w_cls)
            C_R:     begin l_alusrc = 1'b0; l_aluop = 3'b000; l_m2r = 2'b00; end
            C_I:     begin l_aluop = 3'b001; l_m2r = 2'b00; end
            C_LOAD:  begin l_aluop = 3'b010; l_m2r = 2'b01; end
            C_STORE: begin l_aluop = 3'b011; end
            C_BR:    begin l_alusrc = 1'b0; l_aluop = 3'b100; l_branch = 1'b1; end
            C_JAL:   begin l_aluop = 3'b101; l_m2r = 2'b10; end
            C_JALR:  begin l_aluop = 3'b001; l_mux = 1'b1; l_m2r = 2'b10; end
            C_LUI:   begin l_aluop = 3'b110; l_m2r = 2'b10; end
            C_AUIPC: begin l_aluop = 3'b000; l_m2r = 2'b10; end
            default: begin l_alusrc = 1'b0; end
        endcase

        bus.state     = state_q;
        bus.imem_req  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.pc_write  = 1'b0;
        bus.retire    = 1'b0;
        bus.trap      = 1'b0;
        bus.branch    = 1'b0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.alusrc    = 1'b0;
        bus.reg_write = 1'b0;
        bus.mux_inp   = 1'b0;
        bus.memtoreg  = 2'b11;
        bus.aluop     = 3'b000;

        if (rst_n) begin
            // ALU controls persist from EXEC through MEM and WB of the same instruction
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                bus.alusrc  = l_alusrc;
                bus.aluop   = l_aluop;
                bus.mux_inp = l_mux;
            end
            case (state_q)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.imem_ready;
                end
                S_EXEC: begin
                    bus.branch = l_branch;
                    if (w_cls == C_BR) begin
                        bus.pc_write = 1'b1;
                        bus.retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    bus.memread  = (w_cls == C_LOAD);
                    bus.memwrite = (w_cls == C_STORE);
                    if ((w_cls == C_STORE) && bus.dmem_ready) begin
                        bus.pc_write = 1'b1;
                        bus.retire   = 1'b1;
                    end
                end
                S_WB: begin
                    bus.reg_write = 1'b1;
                    bus.pc_write  = 1'b1;
                    bus.retire    = 1'b1;
                    bus.memtoreg  = l_m2r;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
